// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the uart_rx frame controller.
package uart_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  // Reason codes reported alongside frame_err
  typedef enum logic [1:0] {
    ERR_LINE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Inter-byte gap in clocks: to_bytes character times of 10 bits each.
  // Computed in 64 bits because to_bytes*10*fclk overflows 32-bit int quickly.
  function automatic longint gap_clocks(input int to_bytes, input int fclk, input int baud);
    return (longint'(to_bytes) * 64'd10 * longint'(fclk)) / longint'(baud);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receive-side and payload-stream signals of the frame controller.
// Stream handshake: a beat transfers on a clock edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready is low the
// producer holds m_data and m_last stable, and m_valid never drops
// before the transfer completes.
interface uart_rx_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  // Frame controller side
  modport master (
    input  rx_data, rx_ready, rx_error, m_ready,
    output m_data, m_valid, m_last
  );

  // Environment side: uart_rx plus payload consumer
  modport slave (
    output rx_data, rx_ready, rx_error, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload register file: synchronous write, combinational read, no reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: parses SOF, LEN, payload, CHK, buffers
// the payload and releases it on the stream only when the checksum passes.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         fclk     = 50_000_000,
  parameter int         baud     = 115_200,
  parameter logic [7:0] SOF      = SOF_DEFAULT,
  parameter int         MAX_LEN  = 16,
  parameter int         TO_BYTES = 4
) (
  input  logic                  clk50m,
  input  logic                  rst_n,
  uart_rx_frame_ctrl_if.master  bus,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  overrun,
  output logic                  busy,
  output state_t                state_dbg
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam longint GAP_CLK = gap_clocks(TO_BYTES, fclk, baud);
  localparam int GAP_W = $clog2(GAP_CLK + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLK);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state, state_nxt;
  err_t             err_q, err_nxt;
  logic             rdy_q;
  logic             stb;
  logic [IDX_W-1:0] len, wr_idx, rd_idx;
  logic [7:0]       sum;
  logic [7:0]       chk_sum;
  logic [GAP_W-1:0] gap;
  logic             gap_zero;
  logic             active;
  logic             len_bad;
  logic             last_wr, last_rd;
  logic             xfer;
  logic [7:0]       rdata;

  logic err_fire, ok_fire, ovr_fire;
  logic len_ld, sum_ld, sum_add, wr_clr, wr_inc, rd_clr, rd_inc, buf_we;

  // One strobe per byte: rising edge of the level-style ready flag
  assign stb      = bus.rx_ready & ~rdy_q;
  assign chk_sum  = sum + bus.rx_data;
  assign gap_zero = (gap == '0);
  assign active   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
  assign len_bad  = (bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_LEN));
  assign last_wr  = (wr_idx == len - IDX_ONE);
  assign last_rd  = (rd_idx == len - IDX_ONE);
  assign xfer     = (state == ST_SEND) && bus.m_ready;

  // Moore outputs; m_data is forced low outside SEND so idle outputs read 0
  assign bus.m_valid = (state == ST_SEND);
  assign bus.m_last  = (state == ST_SEND) && last_rd;
  assign bus.m_data  = (state == ST_SEND) ? rdata : 8'h00;
  assign busy        = (state != ST_HUNT);
  assign err_code    = err_q;
  assign state_dbg   = state;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .clk   (clk50m),
    .we    (buf_we),
    .waddr (wr_idx[BUF_AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (rd_idx[BUF_AW-1:0]),
    .rdata (rdata)
  );

  // State register
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  // Next-state and datapath control; line error outranks LEN/CHK checks,
  // and a strobe in the same cycle as gap expiry is processed as a byte
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    err_fire  = 1'b0;
    ok_fire   = 1'b0;
    ovr_fire  = 1'b0;
    len_ld    = 1'b0;
    sum_ld    = 1'b0;
    sum_add   = 1'b0;
    wr_clr    = 1'b0;
    wr_inc    = 1'b0;
    rd_clr    = 1'b0;
    rd_inc    = 1'b0;
    buf_we    = 1'b0;
    case (state)
      ST_HUNT: begin
        if (stb && !bus.rx_error && (bus.rx_data == SOF)) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (stb) begin
          if (bus.rx_error) begin
            err_fire = 1'b1; err_nxt = ERR_LINE; state_nxt = ST_HUNT;
          end else begin
            len_ld = 1'b1;
            sum_ld = 1'b1;
            if (len_bad) begin
              err_fire = 1'b1; err_nxt = ERR_LEN; state_nxt = ST_HUNT;
            end else begin
              wr_clr = 1'b1; state_nxt = ST_PAYLOAD;
            end
          end
        end else if (gap_zero) begin
          err_fire = 1'b1; err_nxt = ERR_TIMEOUT; state_nxt = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (stb) begin
          if (bus.rx_error) begin
            err_fire = 1'b1; err_nxt = ERR_LINE; state_nxt = ST_HUNT;
          end else begin
            buf_we  = 1'b1;
            sum_add = 1'b1;
            wr_inc  = 1'b1;
            if (last_wr) state_nxt = ST_CHK;
          end
        end else if (gap_zero) begin
          err_fire = 1'b1; err_nxt = ERR_TIMEOUT; state_nxt = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (stb) begin
          if (bus.rx_error) begin
            err_fire = 1'b1; err_nxt = ERR_LINE; state_nxt = ST_HUNT;
          end else if (chk_sum == 8'h00) begin
            ok_fire = 1'b1; rd_clr = 1'b1; state_nxt = ST_SEND;
          end else begin
            err_fire = 1'b1; err_nxt = ERR_CHK; state_nxt = ST_HUNT;
          end
        end else if (gap_zero) begin
          err_fire = 1'b1; err_nxt = ERR_TIMEOUT; state_nxt = ST_HUNT;
        end
      end
      ST_SEND: begin
        ovr_fire = stb;
        if (xfer) begin
          rd_inc = 1'b1;
          if (last_rd) state_nxt = ST_HUNT;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // Edge detector, status pulses and held error reason
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_q     <= ERR_LINE;
    end else begin
      rdy_q     <= bus.rx_ready;
      frame_ok  <= ok_fire;
      frame_err <= err_fire;
      overrun   <= ovr_fire;
      err_q     <= err_nxt;
    end
  end

  // Length, running checksum and buffer index counters
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      len    <= '0;
      sum    <= 8'h00;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (len_ld)  len <= bus.rx_data[IDX_W-1:0];
      if (sum_ld)       sum <= bus.rx_data;
      else if (sum_add) sum <= chk_sum;
      if (wr_clr)       wr_idx <= '0;
      else if (wr_inc)  wr_idx <= wr_idx + IDX_ONE;
      if (rd_clr)       rd_idx <= '0;
      else if (rd_inc)  rd_idx <= rd_idx + IDX_ONE;
    end
  end

  // Inter-byte gap counter: reloads on each byte, runs only mid-frame
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      gap <= '0;
    end else if (stb) begin
      gap <= GAP_LOAD;
    end else if (active && !gap_zero) begin
      gap <= gap - GAP_ONE;
    end
  end

endmodule
